// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer for the 8-bit CPU: steps each instruction through
// fetch/decode/execute/mem/writeback and drives the PC, register-file and memory strobes.
module cpu_sequencer (
    input  logic        clkDiv,
    input  logic        reset,
    input  logic        run,
    input  logic        step,
    input  logic [7:0]  instr,
    output logic [7:0]  ir,
    output logic        pc_en,
    output logic        branch,
    output logic [7:0]  bdata,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        alu_src,
    output logic [2:0]  state,
    output logic        halted,
    output logic [15:0] retired
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_LW  = 2'b01,
        OP_SW  = 2'b10,
        OP_J   = 2'b11
    } opcode_t;

    // A jump with offset -1 targets itself; it parks the machine instead of spinning.
    localparam logic [7:0] JUMP_SELF = 8'hFF;

    state_t  cur_state;
    state_t  next_state;
    logic    step_mode;
    logic    step_mode_next;
    logic    ir_load;
    logic    complete;
    logic    retire;
    opcode_t op;
    logic    mem_op;

    assign op     = opcode_t'(ir[7:6]);
    assign mem_op = (op == OP_LW) || (op == OP_SW);
    assign state  = cur_state;

    // NOTE: every register here changes with non-blocking assignments so all of them
    // sample the same pre-edge values; blocking writes would make the order of lines matter.
    always_ff @(posedge clkDiv or posedge reset) begin
        if (reset) begin
            cur_state <= IDLE;
            step_mode <= 1'b0;
            ir        <= 8'h00;
            retired   <= 16'h0000;
        end else begin
            cur_state <= next_state;
            step_mode <= step_mode_next;
            if (ir_load) begin
                ir <= instr;
            end
            if (retire) begin
                retired <= retired + 16'd1;
            end
        end
    end

    // NOTE: every signal written below gets a default first, so no path through the
    // case statement can leave one unassigned and infer a latch.
    always_comb begin
        next_state     = cur_state;
        step_mode_next = step_mode;
        ir_load        = 1'b0;
        complete       = 1'b0;
        retire         = 1'b0;
        pc_en          = 1'b0;
        branch         = 1'b0;
        bdata          = 8'h00;
        reg_write      = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        alu_src        = 1'b0;
        halted         = 1'b0;

        case (cur_state)
            IDLE: begin
                if (run) begin
                    next_state = FETCH;
                end else if (step) begin
                    next_state     = FETCH;
                    step_mode_next = 1'b1;
                end
            end
            FETCH: begin
                ir_load    = 1'b1;
                next_state = DECODE;
            end
            DECODE: begin
                alu_src    = mem_op;
                next_state = EXEC;
            end
            EXEC: begin
                alu_src = mem_op;
                case (op)
                    OP_ADD: next_state = WB;
                    OP_LW,
                    OP_SW:  next_state = MEM;
                    default: begin
                        if (ir == JUMP_SELF) begin
                            next_state = HALT;
                            retire     = 1'b1;
                        end else begin
                            pc_en    = 1'b1;
                            branch   = 1'b1;
                            bdata    = {{2{ir[5]}}, ir[5:0]};
                            complete = 1'b1;
                        end
                    end
                endcase
            end
            MEM: begin
                alu_src = mem_op;
                if (op == OP_LW) begin
                    mem_read   = 1'b1;
                    next_state = WB;
                end else begin
                    mem_write = 1'b1;
                    pc_en     = 1'b1;
                    complete  = 1'b1;
                end
            end
            WB: begin
                alu_src   = mem_op;
                reg_write = 1'b1;
                pc_en     = 1'b1;
                complete  = 1'b1;
            end
            HALT: begin
                halted = 1'b1;
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        // A finished instruction either chains into the next fetch or parks in IDLE.
        if (complete) begin
            retire = 1'b1;
            if (run && !step_mode) begin
                next_state = FETCH;
            end else begin
                next_state     = IDLE;
                step_mode_next = 1'b0;
            end
        end
    end

endmodule
